// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, the instruction register, the halt latch
// and the retired-instruction counter; issues icache reads one instruction at a time.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic [1:0]  PCSrc,
  input  logic        branch_cond,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] retired
);

  // state  | meaning
  // REQ    | read request outstanding, waiting for ihit
  // HOLD   | instruction held in instr, waiting for advance
  // HALTED | fetch stopped until reset
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        unused_jr_low;

  assign iaddr         = pc;
  assign pc_plus4      = pc + 32'd4;
  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  // jump-register targets are silently word-aligned rather than trapped
  assign unused_jr_low = ^jr_addr[1:0];

  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      2'd1:    if (branch_cond) next_pc = pc_plus4 + branch_off;
      2'd2:    next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'd3:    next_pc = {jr_addr[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      retired     <= 32'd0;
      iREN        <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (ihit) begin
            instr       <= iload;
            state       <= S_HOLD;
            iREN        <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (advance) begin
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            if (halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
              iREN  <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state       <= S_REQ;
          iREN        <= 1'b1;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a small PC/counter model feeds expected
// instruction words and fetch addresses into queues that are popped as the DUT responds.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        advance = 1'b0;
  logic [1:0]  PCSrc = 2'd0;
  logic        branch_cond = 1'b0;
  logic [31:0] jr_addr = 32'd0;
  logic        halt = 1'b0;
  logic        halted;
  logic [31:0] retired;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .pc_plus4(pc_plus4), .advance(advance), .PCSrc(PCSrc), .branch_cond(branch_cond),
    .jr_addr(jr_addr), .halt(halt), .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_addr[$];
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_instr = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [1:0] src, input logic bc,
                                             input logic [31:0] jr);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    case (src)
      2'd1:    return bc ? seq + (off << 2) : seq;
      2'd2:    return {seq[31:28], ins[25:0], 2'b00};
      2'd3:    return jr & 32'hFFFF_FFFC;
      default: return seq;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_iren"}, {31'd0, iREN}, 32'd1);
    chk({tag, "_iaddr"}, iaddr, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_opcode"}, {26'd0, opcode}, 32'd0);
    chk({tag, "_funct"}, {26'd0, funct}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
    chk({tag, "_pc4"}, pc_plus4, 32'd4);
  endtask

  task automatic do_reset();
    ihit = 1'b0;
    advance = 1'b0;
    halt = 1'b0;
    nRST = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    nRST = 1'b1;
    m_pc = 32'd0;
    m_ret = 32'd0;
    q_instr.delete();
    q_addr.delete();
  endtask

  // Fetch one word after `delay` idle request cycles; an advance pulse during REQ must be ignored.
  task automatic fetch(input logic [31:0] word, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("wait_iren", {31'd0, iREN}, 32'd1);
      chk("wait_iaddr", iaddr, m_pc);
      chk("wait_retired", retired, m_ret);
      advance = (i == 1);
      tick();
      advance = 1'b0;
    end
    chk("req_iren", {31'd0, iREN}, 32'd1);
    chk("req_iaddr", iaddr, m_pc);
    ihit = 1'b1;
    iload = word;
    q_instr.push_back(word);
    tick();
    ihit = 1'b0;
    iload = $urandom;
    chk("hold_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("hold_iren", {31'd0, iREN}, 32'd0);
    chk("hold_retired", retired, m_ret);
    if (q_instr.size() > 0) begin
      m_instr = q_instr.pop_front();
      chk("instr", instr, m_instr);
      chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
      chk("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
  endtask

  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      PCSrc = 2'($urandom);
      branch_cond = 1'($urandom);
      jr_addr = $urandom;
      halt = 1'($urandom);
      tick();
      chk("idle_instr", instr, m_instr);
      chk("idle_iaddr", iaddr, m_pc);
      chk("idle_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("idle_iren", {31'd0, iREN}, 32'd0);
      chk("idle_retired", retired, m_ret);
    end
    halt = 1'b0;
  endtask

  task automatic retire(input logic [1:0] src, input logic bc, input logic [31:0] jr,
                        input logic hlt);
    if (!hlt) q_addr.push_back(model_next(m_pc, m_instr, src, bc, jr));
    PCSrc = src;
    branch_cond = bc;
    jr_addr = jr;
    halt = hlt;
    advance = 1'b1;
    tick();
    advance = 1'b0;
    halt = 1'b0;
    PCSrc = 2'($urandom);
    branch_cond = 1'($urandom);
    jr_addr = $urandom;
    m_ret = m_ret + 32'd1;
    chk("ret_count", retired, m_ret);
    chk("ret_ivalid", {31'd0, instr_valid}, 32'd0);
    if (hlt) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_iren", {31'd0, iREN}, 32'd0);
      chk("halt_iaddr", iaddr, m_pc);
    end else if (q_addr.size() > 0) begin
      m_pc = q_addr.pop_front();
      chk("next_iaddr", iaddr, m_pc);
      chk("next_iren", {31'd0, iREN}, 32'd1);
      chk("next_halted", {31'd0, halted}, 32'd0);
    end
  endtask

  initial begin
    do_reset();

    // First fetch with a 3-cycle hit delay.
    fetch(32'h2002_0005, 3);
    chk("first_opcode", {26'd0, opcode}, 32'h08);
    retire(2'd3, 1'b0, 32'h0000_0010, 1'b0);
    chk("pc_0x10", iaddr, 32'h10);

    // Straight line at 0x10.
    fetch(32'h0085_1020, 1);
    retire(2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("seq_0x14", iaddr, 32'h14);
    chk("seq_retired", retired, 32'd2);

    // Branch at 0x20, taken and not taken, with some idle HOLD cycles.
    fetch(32'h0000_0000, 0);
    retire(2'd3, 1'b0, 32'h0000_0020, 1'b0);
    fetch(32'h1000_FFFE, 2);
    hold_idle(3);
    retire(2'd1, 1'b1, 32'h0, 1'b0);
    chk("br_taken", iaddr, 32'h1C);
    fetch(32'h0000_0000, 0);
    retire(2'd3, 1'b1, 32'h0000_0020, 1'b0);
    fetch(32'h1000_FFFE, 0);
    retire(2'd1, 1'b0, 32'h0, 1'b0);
    chk("br_not_taken", iaddr, 32'h24);

    // Jump within the 0x3 region, then jump-register with misaligned target.
    fetch(32'h0000_0000, 1);
    retire(2'd3, 1'b0, 32'h3000_0040, 1'b0);
    fetch(32'h0800_0010, 1);
    retire(2'd2, 1'b0, 32'h0, 1'b0);
    chk("jump", iaddr, 32'h3000_0040);
    fetch(32'h03E0_0008, 0);
    retire(2'd3, 1'b0, 32'h0000_0107, 1'b0);
    chk("jr_align", iaddr, 32'h104);

    // Counter wrap.
    fetch(32'h0000_0000, 0);
    dut.retired = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    retire(2'd0, 1'b0, 32'h0, 1'b0);
    chk("wrap", retired, 32'd0);

    // Halt, then confirm it is terminal.
    fetch(32'hFC00_0000, 1);
    retire(2'd3, 1'b1, 32'h0000_0800, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ihit = 1'b1;
      advance = 1'b1;
      iload = $urandom;
      PCSrc = 2'd3;
      jr_addr = $urandom;
      tick();
      chk("halt_stay", {31'd0, halted}, 32'd1);
      chk("halt_noreq", {31'd0, iREN}, 32'd0);
      chk("halt_pc", iaddr, m_pc);
      chk("halt_retired", retired, m_ret);
      chk("halt_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    ihit = 1'b0;
    advance = 1'b0;

    // Asynchronous reset while holding an instruction.
    do_reset();
    fetch(32'h2002_0005, 0);
    retire(2'd0, 1'b0, 32'h0, 1'b0);
    fetch(32'h8C22_0004, 1);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("async");
    #2;
    nRST = 1'b1;
    m_pc = 32'd0;
    m_ret = 32'd0;
    tick();
    chk("resume_iren", {31'd0, iREN}, 32'd1);
    chk("resume_iaddr", iaddr, 32'd0);
    fetch(32'h2402_000A, 0);
    retire(2'd0, 1'b0, 32'h0, 1'b0);
    chk("resume_next", iaddr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
